// File: rtl/learntc_loader_if.sv
// learntc_loader_if: literal stream from conflict analysis and write port toward the clause array
interface learntc_loader_if #(
  parameter int NUM_CLAUSES_A_BIN = 4,
  parameter int NUM_VARS_A_BIN = 8,
  parameter int WIDTH_C_LEN = 5,
  parameter int WIDTH_VAR_INDEX = 3
);
  logic lit_valid_i, lit_ready_o, lit_sign_i, lit_last_i, done_o, err_o;
  logic [WIDTH_VAR_INDEX-1:0] lit_var_i;
  logic [NUM_CLAUSES_A_BIN-1:0] learntc_insert_index_i, wr_o;
  logic [WIDTH_C_LEN-1:0] clause_len_o;
  logic [NUM_VARS_A_BIN*3-1:0] var_value_o;
  modport master (
    input lit_valid_i, lit_var_i, lit_sign_i, lit_last_i, learntc_insert_index_i,
    output lit_ready_o, wr_o, clause_len_o, var_value_o, done_o, err_o
  );
  modport slave (
    output lit_valid_i, lit_var_i, lit_sign_i, lit_last_i, learntc_insert_index_i,
    input lit_ready_o, wr_o, clause_len_o, var_value_o, done_o, err_o
  );
endinterface

// File: rtl/learntc_loader.sv
// learntc_loader: assembles a serial learnt clause and writes it to the clause array in one cycle; define LEARNTC_LOADER_TAUTOLOGY_CHECK_EN to discard clauses holding both signs of a variable
module learntc_loader #(
  parameter int NUM_CLAUSES_A_BIN = 4,
  parameter int NUM_VARS_A_BIN = 8,
  parameter int WIDTH_C_LEN = 5,
  parameter int WIDTH_VAR_INDEX = 3
) (
  input logic clk,
  input logic rst,
  learntc_loader_if.master bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state;
  logic [NUM_VARS_A_BIN-1:0][2:0] buffer;
  logic [WIDTH_C_LEN-1:0] len;
  logic [WIDTH_VAR_INDEX-1:0] v;
  logic [NUM_CLAUSES_A_BIN-1:0] idx;
  logic [2:0] lit, field;
  logic err, ready, done, err_out, in_range, idx_ok, accept;
  // decode the incoming beat and the target row
  always_comb begin
    v = bus.lit_var_i;
    idx = bus.learntc_insert_index_i;
    lit = bus.lit_sign_i ? 3'b001 : 3'b010;
    in_range = 32'(v) < NUM_VARS_A_BIN;
    field = in_range ? buffer[v] : 3'b000;
    accept = bus.lit_valid_i && ready;
    idx_ok = $onehot(idx) && ((idx >> (NUM_CLAUSES_A_BIN / 2)) == '0);
    bus.wr_o = (state == WRITE && idx_ok && !err) ? idx : '0;
    bus.clause_len_o = |bus.wr_o ? len : '0;
    bus.var_value_o = |bus.wr_o ? buffer : '0;
    bus.lit_ready_o = ready;
    bus.done_o = done;
    bus.err_o = err_out;
  end
  // clause FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      buffer <= '0;
      len <= '0;
      err <= 1'b0;
      ready <= 1'b0;
      done <= 1'b0;
      err_out <= 1'b0;
    end else case (state)
      IDLE, COLLECT: begin
        ready <= 1'b1;
        if (accept) begin
          if (!in_range) err <= 1'b1;
          else if (field == 3'b000) begin
            buffer[v] <= lit;
            if (len < WIDTH_C_LEN'(NUM_VARS_A_BIN)) len <= len + 1'b1;
          end else if (field != lit)
`ifdef LEARNTC_LOADER_TAUTOLOGY_CHECK_EN
            err <= 1'b1;
`else
            buffer[v] <= lit;
`endif
          state <= bus.lit_last_i ? WRITE : COLLECT;
          ready <= !bus.lit_last_i;
        end
      end
      WRITE: begin
        err <= err || !idx_ok;
        err_out <= err || !idx_ok;
        done <= 1'b1;
        state <= DONE;
      end
      default: begin
        buffer <= '0;
        len <= '0;
        err <= 1'b0;
        done <= 1'b0;
        err_out <= 1'b0;
        ready <= 1'b1;
        state <= IDLE;
      end
    endcase
endmodule

// File: tb/tb_learntc_loader.sv
// tb_learntc_loader: directed and random clauses checked against a set-of-literals reference model
module tb_learntc_loader;
  logic clk = 1'b0, rst = 1'b0;
  int tests = 0, fails = 0;
  logic [2:0] q_var[$];
  logic q_sign[$];
  logic [3:0] idx_tab[8];
  always #5 clk = ~clk;
  learntc_loader_if bus ();
  learntc_loader dut (.clk(clk), .rst(rst), .bus(bus));
  // one comparison: counts and reports a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // send the queued clause and check the write and done cycles against the model
  task automatic run(input logic [3:0] idx);
    int field[8];
    bit taut = 0, bad;
    int len = 0, w;
    logic [23:0] val = '0;
    foreach (field[i]) field[i] = 0;
    foreach (q_var[k]) begin
      int f = q_sign[k] ? 1 : 2;
      if (field[q_var[k]] != 0 && field[q_var[k]] != f) taut = 1;
      field[q_var[k]] = f;
    end
    foreach (field[i]) begin
      if (field[i] != 0) len++;
      val[3*i +: 3] = 3'(field[i]);
    end
`ifndef LEARNTC_LOADER_TAUTOLOGY_CHECK_EN
    taut = 0;
`endif
    bad = taut || $countones(idx) != 1 || idx > 4'd2;
    bus.learntc_insert_index_i = idx;
    foreach (q_var[k]) begin
      w = 0;
      while (!bus.lit_ready_o && w < 10) begin @(posedge clk); #1; w++; end
      check("ready", 32'(bus.lit_ready_o), 1);
      bus.lit_valid_i = 1'b1;
      bus.lit_var_i = q_var[k];
      bus.lit_sign_i = q_sign[k];
      bus.lit_last_i = (k == q_var.size() - 1);
      @(posedge clk); #1;
    end
    bus.lit_valid_i = 1'b0;
    bus.lit_last_i = 1'b0;
    check("wr", 32'(bus.wr_o), bad ? 0 : 32'(idx));
    check("len", 32'(bus.clause_len_o), bad ? 0 : len);
    check("value", 32'(bus.var_value_o), bad ? 0 : 32'(val));
    check("ready_write", 32'(bus.lit_ready_o), 0);
    check("done_early", 32'(bus.done_o), 0);
    @(posedge clk); #1;
    check("done", 32'(bus.done_o), 1);
    check("err", 32'(bus.err_o), 32'(bad));
    check("wr_done", 32'(bus.wr_o), 0);
    @(posedge clk); #1;
    check("done_clear", 32'(bus.done_o), 0);
    check("ready_after", 32'(bus.lit_ready_o), 1);
  endtask
  initial begin
    idx_tab = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b0000, 4'b1000};
    bus.lit_valid_i = 1'b0;
    bus.lit_var_i = '0;
    bus.lit_sign_i = 1'b0;
    bus.lit_last_i = 1'b0;
    bus.learntc_insert_index_i = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.lit_ready_o), 0);
    check("rst_wr", 32'(bus.wr_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_len", 32'(bus.clause_len_o), 0);
    check("rst_value", 32'(bus.var_value_o), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_first_edge", 32'(bus.lit_ready_o), 1);
    q_var = '{3'd1, 3'd4, 3'd6}; q_sign = '{1'b0, 1'b1, 1'b0}; run(4'b0010);
    q_var = '{3'd0}; q_sign = '{1'b1}; run(4'b0001);
    q_var = '{3'd2, 3'd2, 3'd3}; q_sign = '{1'b0, 1'b0, 1'b0}; run(4'b0001);
    q_var = '{3'd2, 3'd2}; q_sign = '{1'b0, 1'b1}; run(4'b0010);
    q_var = '{3'd5, 3'd7}; q_sign = '{1'b0, 1'b1}; run(4'b0100);
    q_var = '{3'd5}; q_sign = '{1'b0}; run(4'b0001);
    q_var = '{3'd3, 3'd0}; q_sign = '{1'b1, 1'b1}; run(4'b0011);
    q_var = '{3'd6}; q_sign = '{1'b1}; run(4'b0010);
    q_var = '{3'd1}; q_sign = '{1'b0}; run(4'b0000);
    q_var = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    q_sign = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run(4'b0001);
    for (int k = 0; k < 2; k++) begin
      bus.lit_valid_i = 1'b1;
      bus.lit_var_i = 3'(k);
      bus.lit_sign_i = 1'b0;
      bus.lit_last_i = 1'b0;
      @(posedge clk); #1;
    end
    bus.lit_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.lit_ready_o), 0);
    check("midrst_wr", 32'(bus.wr_o), 0);
    check("midrst_len", 32'(bus.clause_len_o), 0);
    check("midrst_value", 32'(bus.var_value_o), 0);
    check("midrst_done", 32'(bus.done_o), 0);
    check("midrst_err", 32'(bus.err_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_wr_hold", 32'(bus.wr_o), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    q_var = '{3'd5}; q_sign = '{1'b0}; run(4'b0001);
    for (int c = 0; c < 25; c++) begin
      int n = $urandom_range(1, 6);
      q_var.delete();
      q_sign.delete();
      for (int j = 0; j < n; j++) begin
        q_var.push_back(3'($urandom_range(0, 7)));
        q_sign.push_back(1'($urandom_range(0, 1)));
      end
      run(idx_tab[$urandom_range(0, 7)]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/learntc_loader.md
# learntc_loader

- Collects one learnt clause from conflict analysis as a serial literal stream and assembles it into a per-variable literal vector.
- Writes the clause into the clause array in a single cycle, at the learnt-clause row chosen by the array's insert-index output.
- Sits directly upstream of the clause array: it drives the array's write-enable, clause-length and variable-value inputs, and consumes its learnt-clause insert index.

## Interface
- NUM_CLAUSES_A_BIN, 4, clause rows per bin. Lower NUM_CLAUSES_A_BIN/2 rows are learnt rows.
- NUM_VARS_A_BIN, 8, variables per bin.
- WIDTH_C_LEN, 5, clause-length width.
- WIDTH_VAR_INDEX, 3, variable-index width; equals clog2(NUM_VARS_A_BIN).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- lit_valid_i  in  1  literal beat valid.
- lit_ready_o  out  1  literal beat accepted when high together with lit_valid_i.
- lit_var_i  in  WIDTH_VAR_INDEX  variable index within the bin.
- lit_sign_i  in  1  1 = negative literal, 0 = positive literal.
- lit_last_i  in  1  last literal of the clause.
- learntc_insert_index_i  in  NUM_CLAUSES_A_BIN  one-hot target row from the clause array.
- wr_o  out  NUM_CLAUSES_A_BIN  one-hot row write strobe to the clause array.
- clause_len_o  out  WIDTH_C_LEN  length of the clause being written.
- var_value_o  out  NUM_VARS_A_BIN*3  literal field per variable; variable i occupies bits [3i+2:3i].
- done_o  out  1  one-cycle pulse when a clause is finished.
- err_o  out  1  status, valid only while done_o is high; 1 = clause discarded.

## Operation
- Literal field encoding:
  - 3'b000: variable absent.
  - 3'b010: positive literal.
  - 3'b001: negative literal.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: lit_ready_o=1. An accepted beat stores the literal, sets len=1, and moves to COLLECT. If lit_last_i=1 on that beat, it moves directly to WRITE.
- COLLECT: lit_ready_o=1. Each accepted beat updates the field of lit_var_i:
  - Field absent: store the literal and increment len.
  - Same sign already stored: duplicate; field and len unchanged.
  - Opposite sign already stored: handled as described under Configuration.
  - If lit_last_i=1 on the beat, move to WRITE.
- WRITE (exactly one cycle, lit_ready_o=0):
  - Sample learntc_insert_index_i.
  - Valid index: exactly one bit set, and that bit is in the lower NUM_CLAUSES_A_BIN/2 positions.
  - Valid and no pending error: wr_o equals the index for this cycle, with clause_len_o=len and var_value_o=buffer.
  - Otherwise: wr_o=0 and the error flag is set.
  - Go to DONE.
- DONE (one cycle): done_o=1 and err_o=error flag. The buffer, len and error flag clear, and the FSM returns to IDLE.
- len saturates at NUM_VARS_A_BIN; it cannot exceed this because each variable holds at most one literal. WIDTH_C_LEN must satisfy 2^WIDTH_C_LEN > NUM_VARS_A_BIN.
- lit_var_i >= NUM_VARS_A_BIN is out of range: the beat is accepted, the buffer is unchanged, and the error flag is set.

## Timing
- Reset values: all outputs 0, including lit_ready_o; FSM=IDLE; buffer=0; len=0.
- After reset deassertion, lit_ready_o=1 from the first clock edge.
- Reset asserted mid-clause: the clause is abandoned, no write is issued, and the FSM returns to IDLE.
- Latency: last beat accepted at edge N → wr_o high in cycle N+1 → done_o high in cycle N+2. The next beat can be accepted at edge N+3.
- Throughput: one literal per cycle while in IDLE/COLLECT.
- clause_len_o and var_value_o are driven only while wr_o≠0, and are 0 otherwise.
- wr_o is never high for more than one cycle per clause.

## Configuration
- LEARNTC_LOADER_TAUTOLOGY_CHECK_EN defined: an opposite-sign literal on an already-stored variable sets the error flag. The clause is then discarded in WRITE (wr_o=0) and reported with err_o=1.
- LEARNTC_LOADER_TAUTOLOGY_CHECK_EN not defined: the field is overwritten with the newest sign, len is unchanged, and no error is raised.

## Test plan
- Clause: (v1,+), (v4,−), (v6,+ last); insert index 4'b0010. Required response:
  - wr_o=4'b0010 at cycle N+1.
  - clause_len_o=3.
  - var_value_o field1=010, field4=001, field6=010, all other fields 000.
  - done_o=1 and err_o=0 at N+2.
- Single literal (v0,−) with last, index 4'b0001 → wr_o=4'b0001, clause_len_o=1, done_o two cycles after the beat.
- Duplicate literal: (v2,+), (v2,+), (v3,+ last) → clause_len_o=2, normal write.
- Opposite-sign literal: (v2,+), (v2,− last).
  - With the macro defined: wr_o stays 0, and done_o=1 with err_o=1.
  - Without the macro: wr_o=index, clause_len_o=1, field2=001.
- Bad insert index:
  - 4'b0100 (upper half): no write, err_o=1.
  - 4'b0011 (two bits set): no write, err_o=1.
  - 4'b0000 (no bit set): no write, err_o=1.
  - In each case the next clause then writes normally.
- Reset asserted after 2 beats of a 4-literal clause → no wr_o pulse and all outputs 0. After release, a fresh 1-literal clause writes with clause_len_o=1.
